// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, state
    );

    modport slave (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, pcen, alucontrol, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for the multicycle MIPS core: sequences the shared
// datapath one state per cycle and decodes the ALU function.
module multicycle_controller (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_controller_if.master       bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam ctrl_t CTRL_NONE = ctrl_t'(15'd0);

    // Moore output table; outputs are registered alongside the state so they
    // come straight off flops and never glitch with op/funct/zero.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = CTRL_NONE;
        case (s)
            FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
            DECODE:  begin c.alusrcb = 2'b11; end
            MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEMRD:   begin c.iord = 1'b1; end
            MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            RTYPEEX: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            BEQEX:   begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
            ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            ADDIWB:  begin c.regwrite = 1'b1; end
            JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default: c = CTRL_NONE;
        endcase
        return c;
    endfunction

    state_t state_r;
    state_t state_next_s;
    ctrl_t  ctrl_r;
    logic [2:0] alucontrol_s;

    // State register; reset lands in FETCH without waiting for a clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Control register tracking the state register one-for-one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_r <= decode_state(FETCH);
        end else begin
            ctrl_r <= decode_state(state_next_s);
        end
    end

    // Next-state logic; unknown opcodes and unused codes fall back to FETCH.
    always_comb begin
        state_next_s = FETCH;
        case (state_r)
            FETCH: state_next_s = DECODE;
            DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_next_s = MEMADR;
                    OP_RTYPE:     state_next_s = RTYPEEX;
                    OP_BEQ:       state_next_s = BEQEX;
                    OP_ADDI:      state_next_s = ADDIEX;
                    OP_J:         state_next_s = JEX;
                    default:      state_next_s = FETCH;
                endcase
            end
            MEMADR: begin
                if (bus.op == OP_SW) begin
                    state_next_s = MEMWR;
                end else begin
                    state_next_s = MEMRD;
                end
            end
            MEMRD:   state_next_s = MEMWB;
            RTYPEEX: state_next_s = RTYPEWB;
            ADDIEX:  state_next_s = ADDIWB;
            default: state_next_s = FETCH;
        endcase
    end

    // ALU decoder: fixed add/sub for memory and branch, funct field for R-type.
    always_comb begin
        alucontrol_s = 3'b010;
        case (ctrl_r.aluop)
            2'b00: alucontrol_s = 3'b010;
            2'b01: alucontrol_s = 3'b110;
            2'b10: begin
                case (bus.funct)
                    6'b100000: alucontrol_s = 3'b010;
                    6'b100010: alucontrol_s = 3'b110;
                    6'b100100: alucontrol_s = 3'b000;
                    6'b100101: alucontrol_s = 3'b001;
                    6'b101010: alucontrol_s = 3'b111;
                    default:   alucontrol_s = 3'b010;
                endcase
            end
            default: alucontrol_s = 3'b010;
        endcase
    end

    assign bus.state      = state_r;
    assign bus.iord       = ctrl_r.iord;
    assign bus.regdst     = ctrl_r.regdst;
    assign bus.memtoreg   = ctrl_r.memtoreg;
    assign bus.alusrca    = ctrl_r.alusrca;
    assign bus.alusrcb    = ctrl_r.alusrcb;
    assign bus.pcsrc      = ctrl_r.pcsrc;
    assign bus.alucontrol = alucontrol_s;

    // Write enables are gated by reset so nothing commits while it is held low.
    assign bus.memwrite = ctrl_r.memwrite & reset;
    assign bus.irwrite  = ctrl_r.irwrite & reset;
    assign bus.regwrite = ctrl_r.regwrite & reset;
    assign bus.pcen     = (ctrl_r.pcwrite | (ctrl_r.branch & bus.zero)) & reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller: per-cycle vectors
// plus hand sequences for reset, beq zero toggling and mid-instruction reset.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    multicycle_controller_if mif ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic [3:0] st;
        logic [14:0] ctl;
    } vec_t;

    vec_t vecs[$];

    // {iord,memwrite,irwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,pcen,alucontrol}
    function automatic logic [14:0] mk(input logic iord, input logic mw, input logic irw,
                                       input logic rw, input logic rd, input logic m2r,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] pcs, input logic pcen,
                                       input logic [2:0] aluc);
        return {iord, mw, irw, rw, rd, m2r, asa, asb, pcs, pcen, aluc};
    endfunction

    function automatic logic [14:0] dut_ctl();
        return {mif.iord, mif.memwrite, mif.irwrite, mif.regwrite, mif.regdst,
                mif.memtoreg, mif.alusrca, mif.alusrcb, mif.pcsrc, mif.pcen,
                mif.alucontrol};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [5:0] op, input logic [5:0] funct,
                       input logic zero, input logic [3:0] st, input logic [14:0] ctl);
        vec_t v;
        v.name = name; v.op = op; v.funct = funct; v.zero = zero; v.st = st; v.ctl = ctl;
        vecs.push_back(v);
    endtask

    logic [14:0] k_fetch, k_decode, k_memadr, k_memrd, k_memwb, k_memwr;
    logic [14:0] k_rwb, k_addiex, k_addiwb, k_jex;
    logic [5:0]  rfunct [6];
    logic [2:0]  ralu   [6];
    int          exp_seq [5];
    logic        exp_rw  [5];

    initial begin
        k_fetch  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b1,3'b010);
        k_decode = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0,3'b010);
        k_memadr = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,3'b010);
        k_memrd  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,3'b010);
        k_memwb  = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,3'b010);
        k_memwr  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,3'b010);
        k_rwb    = mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,3'b010);
        k_addiex = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,3'b010);
        k_addiwb = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,3'b010);
        k_jex    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b1,3'b010);

        rfunct[0] = 6'b101010; ralu[0] = 3'b111;
        rfunct[1] = 6'b100000; ralu[1] = 3'b010;
        rfunct[2] = 6'b100010; ralu[2] = 3'b110;
        rfunct[3] = 6'b100100; ralu[3] = 3'b000;
        rfunct[4] = 6'b100101; ralu[4] = 3'b001;
        rfunct[5] = 6'b000111; ralu[5] = 3'b010;

        // lw: 0,1,2,3,4
        add("lw.fetch",  6'b100011, 6'd0, 1'b0, 4'd0, k_fetch);
        add("lw.decode", 6'b100011, 6'd0, 1'b1, 4'd1, k_decode);
        add("lw.memadr", 6'b100011, 6'd0, 1'b0, 4'd2, k_memadr);
        add("lw.memrd",  6'b100011, 6'd0, 1'b0, 4'd3, k_memrd);
        add("lw.memwb",  6'b100011, 6'd0, 1'b0, 4'd4, k_memwb);
        // sw: 0,1,2,5
        add("sw.fetch",  6'b101011, 6'd0, 1'b0, 4'd0, k_fetch);
        add("sw.decode", 6'b101011, 6'd0, 1'b0, 4'd1, k_decode);
        add("sw.memadr", 6'b101011, 6'd0, 1'b0, 4'd2, k_memadr);
        add("sw.memwr",  6'b101011, 6'd0, 1'b0, 4'd5, k_memwr);
        // R-type with each funct
        for (int i = 0; i < 6; i++) begin
            add($sformatf("r%0d.fetch", i),  6'b000000, rfunct[i], 1'b0, 4'd0, k_fetch);
            add($sformatf("r%0d.decode", i), 6'b000000, rfunct[i], 1'b0, 4'd1, k_decode);
            add($sformatf("r%0d.ex", i),     6'b000000, rfunct[i], 1'b1, 4'd6,
                mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,ralu[i]));
            add($sformatf("r%0d.wb", i),     6'b000000, rfunct[i], 1'b0, 4'd7, k_rwb);
        end
        // addi: 0,1,9,10
        add("addi.fetch",  6'b001000, 6'd0, 1'b1, 4'd0,  k_fetch);
        add("addi.decode", 6'b001000, 6'd0, 1'b1, 4'd1,  k_decode);
        add("addi.ex",     6'b001000, 6'd0, 1'b1, 4'd9,  k_addiex);
        add("addi.wb",     6'b001000, 6'd0, 1'b1, 4'd10, k_addiwb);
        // beq taken / not taken
        add("beq1.fetch",  6'b000100, 6'd0, 1'b1, 4'd0, k_fetch);
        add("beq1.decode", 6'b000100, 6'd0, 1'b1, 4'd1, k_decode);
        add("beq1.ex",     6'b000100, 6'd0, 1'b1, 4'd8,
            mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b1,3'b110));
        add("beq0.fetch",  6'b000100, 6'd0, 1'b0, 4'd0, k_fetch);
        add("beq0.decode", 6'b000100, 6'd0, 1'b0, 4'd1, k_decode);
        add("beq0.ex",     6'b000100, 6'd0, 1'b0, 4'd8,
            mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,3'b110));
        // j: 0,1,11
        add("j.fetch",  6'b000010, 6'd0, 1'b0, 4'd0,  k_fetch);
        add("j.decode", 6'b000010, 6'd0, 1'b0, 4'd1,  k_decode);
        add("j.jex",    6'b000010, 6'd0, 1'b0, 4'd11, k_jex);
        // unknown opcode: 0,1 then back to FETCH
        add("nop.fetch",  6'b111111, 6'd0, 1'b1, 4'd0, k_fetch);
        add("nop.decode", 6'b111111, 6'd0, 1'b1, 4'd1, k_decode);

        // Reset held over three edges with a lw opcode present
        mif.op = 6'b100011; mif.funct = 6'd0; mif.zero = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 chk("rst.async_state", {12'd0, mif.state}, 16'd0);
        chk("rst.fetch_view", {1'b0, dut_ctl()}, {1'b0, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,3'b010)});
        for (int e = 0; e < 3; e++) begin
            @(negedge clk); #1;
            chk($sformatf("rst.state%0d", e), {12'd0, mif.state}, 16'd0);
            chk($sformatf("rst.we%0d", e),
                {12'd0, mif.pcen, mif.irwrite, mif.regwrite, mif.memwrite}, 16'd0);
        end
        reset = 1'b1;

        // Table: drive inputs, settle, compare, advance one cycle
        foreach (vecs[i]) begin
            mif.op = vecs[i].op; mif.funct = vecs[i].funct; mif.zero = vecs[i].zero;
            #1;
            chk({vecs[i].name, ".state"}, {12'd0, mif.state}, {12'd0, vecs[i].st});
            chk({vecs[i].name, ".ctl"},   {1'b0, dut_ctl()},  {1'b0, vecs[i].ctl});
            @(negedge clk);
        end
        #1 chk("nop.back_to_fetch", {12'd0, mif.state}, 16'd0);

        // beq: pcen follows zero combinationally inside BEQEX
        mif.op = 6'b000100; mif.zero = 1'b0;
        @(negedge clk); #1 chk("beqt.decode", {12'd0, mif.state}, 16'd1);
        @(negedge clk); #1 chk("beqt.ex", {12'd0, mif.state}, 16'd8);
        chk("beqt.z0a", {15'd0, mif.pcen}, 16'd0);
        mif.zero = 1'b1; #1 chk("beqt.z1a", {15'd0, mif.pcen}, 16'd1);
        mif.zero = 1'b0; #1 chk("beqt.z0b", {15'd0, mif.pcen}, 16'd0);
        mif.zero = 1'b1; #1 chk("beqt.z1b", {15'd0, mif.pcen}, 16'd1);
        @(negedge clk); #1 chk("beqt.fetch", {12'd0, mif.state}, 16'd0);

        // lw aborted by reset in MEMRD, then a clean lw
        mif.op = 6'b100011; mif.zero = 1'b0;
        @(negedge clk); #1 chk("abort.decode", {12'd0, mif.state}, 16'd1);
        @(negedge clk); #1 chk("abort.memadr", {12'd0, mif.state}, 16'd2);
        @(negedge clk); #1 chk("abort.memrd", {12'd0, mif.state}, 16'd3);
        chk("abort.memrd_rw", {15'd0, mif.regwrite}, 16'd0);
        reset = 1'b0;
        #1 chk("abort.immediate", {12'd0, mif.state}, 16'd0);
        chk("abort.rw_now", {15'd0, mif.regwrite}, 16'd0);
        @(negedge clk); #1 chk("abort.held", {12'd0, mif.state}, 16'd0);
        chk("abort.we_held", {12'd0, mif.pcen, mif.irwrite, mif.regwrite, mif.memwrite}, 16'd0);
        reset = 1'b1;
        #1 chk("relw.fetch", {12'd0, mif.state}, 16'd0);
        exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 4; exp_seq[4] = 0;
        exp_rw[0] = 1'b0; exp_rw[1] = 1'b0; exp_rw[2] = 1'b0; exp_rw[3] = 1'b1; exp_rw[4] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk($sformatf("relw.state%0d", c), {12'd0, mif.state}, exp_seq[c][15:0]);
            chk($sformatf("relw.rw%0d", c), {15'd0, mif.regwrite}, {15'd0, exp_rw[c]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit for the multicycle MIPS processor. It sequences the shared datapath (PC, instruction register, register file, ALU, and the single unified instruction/data memory) through one Moore FSM, and decodes the ALU operation. It sits beside the datapath inside the processor core; `memwrite` is the same signal the core exports to `top`.

## Interface
- Parameters: none. Opcode and funct encodings are fixed by the supported ISA subset: lw, sw, R-type add/sub/and/or/slt, beq, addi, j.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `op` in 6: instruction[31:26], taken from the instruction register.
- `funct` in 6: instruction[5:0].
- `zero` in 1: ALU zero flag.
- `iord` out 1: memory address mux select; 0 = PC, 1 = ALUOut.
- `memwrite` out 1: data memory write enable.
- `irwrite` out 1: instruction register load enable.
- `regwrite` out 1: register file write enable.
- `regdst` out 1: register write address select; 1 = rd, 0 = rt.
- `memtoreg` out 1: register write data select; 1 = Data register, 0 = ALUOut.
- `alusrca` out 1: ALU A select; 0 = PC, 1 = register A.
- `alusrcb` out 2: ALU B select; 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc` out 2: next-PC select; 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `pcen` out 1: PC load enable.
- `alucontrol` out 3: ALU function code.
- `state` out 4: current FSM state, for debug and the bench.

## Operation
- **State encoding:** FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
- **Transitions:**
  - FETCH→DECODE.
  - DECODE on `op`:
    - 100011 (lw) or 101011 (sw) → MEMADR
    - 000000 → RTYPEEX
    - 000100 → BEQEX
    - 001000 → ADDIEX
    - 000010 → JEX
    - any other opcode → FETCH (treated as a nop)
  - MEMADR: lw→MEMRD, sw→MEMWR.
  - MEMRD→MEMWB.
  - RTYPEEX→RTYPEWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX → FETCH.
  - State codes 12–15 → FETCH.
- **Moore outputs.** Any output not listed for a state is 0.
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- **PC enable:** `pcen` = pcwrite | (branch & zero). It is combinational in `zero`.
- **ALU decode:**
  - aluop 00 → 010 (add).
  - aluop 01 → 110 (sub).
  - aluop 10 → decoded from funct:
    - 100000 → 010
    - 100010 → 110
    - 100100 → 000
    - 100101 → 001
    - 101010 → 111
    - any other funct → 010
  - aluop 11 is never generated; it decodes to 010.
- `aluop`, `pcwrite` and `branch` are internal signals and are not ports.

## Timing
- **Reset:**
  - `reset` low forces state to FETCH immediately, without waiting for a clock edge.
  - While `reset` is low, `memwrite`, `irwrite`, `regwrite` and `pcen` are forced to 0.
  - All other outputs show their FETCH values: alusrcb=01, alucontrol=010, all remaining outputs 0.
- **After reset:** the first FETCH write enables take effect at the first rising edge after `reset` goes high.
- **Reset mid-instruction:** the instruction is aborted and execution restarts at FETCH. No partial register or memory write is committed after `reset` falls.
- **State register:** one state per cycle. Every output except `pcen` and `alucontrol` depends only on the state register, so they are glitch-free relative to `op`, `funct` and `zero`.
- **Decode timing:** `op` is sampled at the DECODE→next edge, i.e. from the IR loaded at the end of FETCH.
- **Instruction latency, in cycles from FETCH entry to the next FETCH entry:**
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - unknown opcode 2
- **beq:** `pcen` is high during BEQEX only when `zero`=1 in that same cycle.

## Test plan
- **Reset:** hold `reset`=0 for 3 edges with `op`=100011.
  - Required: `state`=0 and `pcen`=`irwrite`=`regwrite`=`memwrite`=0 throughout.
  - After release: `state` sequence is 0,1,2,3,4,0.
- **R-type and addi:**
  - `op`=000000, `funct`=101010 → states 0,1,6,7; `alucontrol`=111 in RTYPEEX; `regdst`=`regwrite`=1 in RTYPEWB.
  - `op`=001000 → states 0,1,9,10; `alusrcb`=10 in ADDIEX; `regwrite`=1 and `regdst`=0 in ADDIWB.
- **sw:** `op`=101011 → states 0,1,2,5,0.
  - Required: `memwrite`=1 and `iord`=1 for exactly one cycle (MEMWR); `memwrite`=0 in every other state.
- **beq:** `op`=000100.
  - `zero`=1 → `pcen`=1, `pcsrc`=01, `alucontrol`=110 in BEQEX.
  - `zero`=0 → `pcen`=0.
  - Toggling `zero` within BEQEX makes `pcen` follow it combinationally.
- **j and unknown opcode:**
  - `op`=000010 → states 0,1,11,0 with `pcsrc`=10 and `pcen`=1 in JEX.
  - `op`=111111 → states 0,1,0 with no write enables asserted in DECODE.
- **Mid-instruction reset:** during lw, drop `reset` while in MEMRD (state 3).
  - Required: `state`=0 immediately; `regwrite` never asserted; the next lw completes normally in 5 cycles.
